// File: rtl/uart_tx_fifo_if.sv
// Host-write and transmitter-handshake bundle for uart_tx_fifo.
// The master side is the host plus transmitter; the slave side is the FIFO.
interface uart_tx_fifo_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic                  wr_en;
  logic [7:0]            wr_data;
  logic                  tx_done;
  logic                  tx_start;
  logic [7:0]            data_out;
  logic                  full;
  logic                  empty;
  logic [DEPTH_LOG2:0]   count;

  modport master (
    output wr_en, wr_data, tx_done,
    input  tx_start, data_out, full, empty, count
  );

  modport slave (
    input  wr_en, wr_data, tx_done,
    output tx_start, data_out, full, empty, count
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO feeding a UART transmitter via an active-low tx_start / tx_done handshake.
// Optional sticky overflow flag and port enabled by defining UART_TX_FIFO_OVF_EN.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic              clock,
  input  logic              reset,
  uart_tx_fifo_if.slave     bus
`ifdef UART_TX_FIFO_OVF_EN
  ,
  output logic              overflow
`endif
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] START   = 2'd1;
  localparam logic [1:0] BUSY    = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [1:0]            state;
  logic                  pop;
  logic                  push;
  logic [CNT_W-1:0]      count_nxt;

  // A pop in the same cycle frees a slot, so a write to a full FIFO is still accepted then.
  always_comb begin
    pop  = (state == IDLE) && !bus.empty;
    push = bus.wr_en && (!bus.full || pop);
    count_nxt = bus.count;
    case ({push, pop})
      2'b10:   count_nxt = bus.count + 1'b1;
      2'b01:   count_nxt = bus.count - 1'b1;
      default: count_nxt = bus.count;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= bus.wr_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      bus.tx_start <= 1'b1;
      bus.data_out <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      bus.count    <= '0;
      bus.empty    <= 1'b1;
      bus.full     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      bus.count <= count_nxt;
      bus.empty <= (count_nxt == '0);
      bus.full  <= (count_nxt == CNT_W'(DEPTH));

      case (state)
        IDLE: begin
          if (pop) begin
            bus.data_out <= mem[rd_ptr];
            rd_ptr       <= rd_ptr + 1'b1;
            bus.tx_start <= 1'b0;
            state        <= START;
          end
        end
        START: begin
          bus.tx_start <= 1'b1;
          state        <= BUSY;
        end
        BUSY: begin
          if (bus.tx_done) state <= RELEASE;
        end
        RELEASE: begin
          // Wait for tx_done to drop so one long pulse is never taken as two frames.
          if (!bus.tx_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (bus.wr_en && bus.full && !pop) begin
      overflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: queue-based reference model checked every cycle plus literal expectations.
module tb_uart_tx_fifo;

  localparam int unsigned DEPTH = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #10 clock = ~clock;

  uart_tx_fifo_if #(.DEPTH_LOG2(4)) bus ();
`ifdef UART_TX_FIFO_OVF_EN
  logic overflow;
`endif

  uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef UART_TX_FIFO_OVF_EN
    ,
    .overflow (overflow)
`endif
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transmitter stand-in: automatic done pulse after a delay, or manual level.
  logic auto_tx = 1'b0;
  logic man_done = 1'b0;
  logic auto_done = 1'b0;
  int   done_delay = 100;
  int   done_len = 1;
  bit   pending = 0;
  int   timer = 0;
  int   done_left = 0;
  assign bus.tx_done = auto_tx ? auto_done : man_done;

  always @(negedge clock) begin
    if (reset) begin
      pending = 0; timer = 0; done_left = 0;
    end else if (bus.tx_start === 1'b0) begin
      pending = 1; timer = done_delay;
    end else if (auto_tx && pending) begin
      if (timer > 0) timer--;
      if (timer == 0) begin pending = 0; done_left = done_len; end
    end
    auto_done = (done_left > 0);
    if (done_left > 0) done_left--;
  end

  // Reference model: a byte queue plus a "transmitter free" notion.
  logic [7:0] q[$];
  bit   m_valid = 0;
  bit   m_launch = 0, m_inflight = 0, m_waitfall = 0;
  bit   m_pop, m_push;
  int unsigned m_sz;
  logic [7:0] e_data = '0;
  bit   e_start = 1;
  bit   e_ovf = 0;

  always @(posedge clock) begin
    if (reset) begin
      q.delete();
      m_launch = 0; m_inflight = 0; m_waitfall = 0;
      e_start = 1; e_data = '0; e_ovf = 0; m_valid = 1;
    end else begin
      m_sz   = q.size();
      m_pop  = !m_launch && !m_inflight && !m_waitfall && (m_sz > 0);
      m_push = bus.wr_en && ((m_sz < DEPTH) || m_pop);
      if (bus.wr_en && (m_sz == DEPTH) && !m_pop) e_ovf = 1;
      if (m_waitfall && !bus.tx_done) m_waitfall = 0;
      if (m_inflight && bus.tx_done) begin m_inflight = 0; m_waitfall = 1; end
      if (m_launch) begin m_launch = 0; m_inflight = 1; end
      if (m_pop) begin e_data = q.pop_front(); m_launch = 1; end
      if (m_push) q.push_back(bus.wr_data);
      e_start = !m_launch;
    end
  end

  logic [7:0] launched[$];

  always @(negedge clock) begin
    if (m_valid) begin
      chk("tx_start", int'(bus.tx_start), int'(e_start));
      chk("data_out", int'(bus.data_out), int'(e_data));
      chk("count",    int'(bus.count),    int'(q.size()));
      chk("empty",    int'(bus.empty),    int'(q.size() == 0));
      chk("full",     int'(bus.full),     int'(q.size() == DEPTH));
`ifdef UART_TX_FIFO_OVF_EN
      chk("overflow", int'(overflow), int'(e_ovf));
`endif
      if (bus.tx_start === 1'b0) launched.push_back(bus.data_out);
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
  endtask

  task automatic burst(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      tick(); bus.wr_en = 1'b1; bus.wr_data = first + 8'(i);
    end
    tick(); bus.wr_en = 1'b0;
  endtask

  task automatic wait_launches(input string name, input int target, input int budget);
    int k = 0;
    while ((launched.size() < target) && (k < budget)) begin tick(); k++; end
    chk(name, launched.size(), target);
  endtask

  task automatic chk_ovf(input string name, input int exp);
`ifdef UART_TX_FIFO_OVF_EN
    chk(name, int'(overflow), exp);
`else
    if (exp > 1) chk(name, 0, exp);
`endif
  endtask

  int base;

  initial begin
    bus.wr_en = 1'b0;
    bus.wr_data = '0;
    ticks(3);
    reset = 1'b0;
    chk("rst_count", int'(bus.count), 0);
    chk("rst_empty", int'(bus.empty), 1);
    chk("rst_full", int'(bus.full), 0);
    chk("rst_tx_start", int'(bus.tx_start), 1);
    chk("rst_data_out", int'(bus.data_out), 0);
    chk_ovf("rst_ovf", 0);

    // Single byte: launch one cycle after the write, tx_start low for one cycle.
    auto_tx = 1'b1; done_delay = 100; done_len = 1;
    base = launched.size();
    tick(); bus.wr_en = 1'b1; bus.wr_data = 8'hA5;
    tick(); bus.wr_en = 1'b0;
    chk("t1_count_e0", int'(bus.count), 1);
    chk("t1_empty_e0", int'(bus.empty), 0);
    tick();
    chk("t1_tx_start_e1", int'(bus.tx_start), 0);
    chk("t1_data_e1", int'(bus.data_out), 8'hA5);
    chk("t1_count_e1", int'(bus.count), 0);
    chk("t1_empty_e1", int'(bus.empty), 1);
    tick();
    chk("t1_tx_start_e2", int'(bus.tx_start), 1);
    ticks(110);
    chk("t1_launches", launched.size(), base + 1);

    // Five bytes back-to-back, transmitter answers 100 cycles after each launch.
    base = launched.size();
    burst(8'h01, 5);
    wait_launches("t2_launches", base + 5, 1000);
    for (int i = 0; i < 5; i++) chk("t2_order", int'(launched[base + i]), i + 1);
    ticks(110);

    // Stalled transmitter: 0x10 goes to the transmitter, 0x11..0x20 fill all 16 slots, 0x21 is dropped.
    do_reset();
    auto_tx = 1'b0; man_done = 1'b0;
    base = launched.size();
    burst(8'h10, 17);
    chk("t3_count_full", int'(bus.count), 16);
    chk("t3_full", int'(bus.full), 1);
    chk_ovf("t3_ovf_before", 0);
    tick(); bus.wr_en = 1'b1; bus.wr_data = 8'h21;
    tick(); bus.wr_en = 1'b0;
    chk("t3_count_drop", int'(bus.count), 16);
    chk_ovf("t3_ovf_after", 1);
    done_delay = 3; auto_tx = 1'b1;
    wait_launches("t3_launches", base + 17, 2000);
    ticks(20);
    chk("t3_no_extra", launched.size(), base + 17);
    for (int i = 0; i < 17; i++) chk("t3_order", int'(launched[base + i]), 8'h10 + i);
    chk_ovf("t3_ovf_sticky", 1);

    // Long tx_done: exactly one frame retired, next launch two edges after the fall.
    do_reset();
    auto_tx = 1'b0; man_done = 1'b0;
    base = launched.size();
    burst(8'h30, 3);
    ticks(3);
    chk("t4_first", launched.size(), base + 1);
    man_done = 1'b1;
    ticks(5);
    chk("t4_during_pulse", launched.size(), base + 1);
    man_done = 1'b0;
    tick();
    chk("t4_fall_edge_start", int'(bus.tx_start), 1);
    chk("t4_fall_edge_n", launched.size(), base + 1);
    tick();
    chk("t4_relaunch_start", int'(bus.tx_start), 0);
    chk("t4_relaunch_data", int'(bus.data_out), 8'h31);
    done_delay = 5; auto_tx = 1'b1;
    wait_launches("t4_launches", base + 3, 500);
    ticks(20);
    chk("t4_last", int'(launched[base + 2]), 8'h32);

    // Full FIFO, FSM returns to IDLE so pop and write of 0x77 share one edge.
    do_reset();
    auto_tx = 1'b0; man_done = 1'b0;
    base = launched.size();
    burst(8'h40, 17);
    chk("t5_full_before", int'(bus.full), 1);
    man_done = 1'b1;
    ticks(2);
    man_done = 1'b0;
    tick();
    chk("t5_idle_start", int'(bus.tx_start), 1);
    bus.wr_en = 1'b1; bus.wr_data = 8'h77;
    tick(); bus.wr_en = 1'b0;
    chk("t5_count", int'(bus.count), 16);
    chk("t5_full", int'(bus.full), 1);
    chk("t5_tx_start", int'(bus.tx_start), 0);
    chk("t5_data", int'(bus.data_out), 8'h41);
    chk_ovf("t5_ovf", 0);
    done_delay = 3; auto_tx = 1'b1;
    wait_launches("t5_launches", base + 18, 2000);
    ticks(20);
    chk("t5_last", int'(launched[base + 17]), 8'h77);

    // Reset while a frame is in progress with three bytes queued.
    do_reset();
    auto_tx = 1'b0; man_done = 1'b0;
    burst(8'h60, 4);
    ticks(2);
    chk("t6_queued", int'(bus.count), 3);
    do_reset();
    chk("t6_count", int'(bus.count), 0);
    chk("t6_empty", int'(bus.empty), 1);
    chk("t6_tx_start", int'(bus.tx_start), 1);
    chk_ovf("t6_ovf", 0);
    base = launched.size();
    ticks(20);
    chk("t6_quiet", launched.size(), base);
    done_delay = 3; auto_tx = 1'b1;
    burst(8'h99, 1);
    wait_launches("t6_new", base + 1, 50);
    chk("t6_new_data", int'(launched[base]), 8'h99);
    ticks(20);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
